// File: rtl/vec_fifo_reader.sv
// Read-side burst controller: pops a fixed number of entries from a FWFT FIFO and
// forwards them downstream through a 2-entry skid buffer, decoupling i_ready from the pop.
module vec_fifo_reader #(
  parameter  int WIDTH   = 248,
  parameter  int MAX_LEN = 256,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_remaining,
  output logic             o_fifo_read,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         occ_q, occ_d;
  logic [WIDTH-1:0]   head_q, head_d;
  logic [WIDTH-1:0]   tail_q, tail_d;
  logic               pop;
  logic               xfer;

  // Pop only looks at registered state and the empty flag, never at i_ready.
  assign pop  = (state_q == S_RUN) && !i_fifo_empty && (rem_q != '0) && (occ_q < 2'd2);
  assign xfer = (occ_q != 2'd0) && i_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d = state_q;
    rem_d   = rem_q;
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rem_d   = i_len;
          state_d = (i_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop && (rem_q == LEN_W'(1))) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // No pops happen here, so occupancy 1 plus a transfer means the last entry left.
        if (xfer && (occ_q == 2'd1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) rem_d = rem_q - LEN_W'(1);

    unique case (occ_q)
      2'd0: begin
        if (pop) begin
          head_d = i_fifo_data;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && xfer) begin
          head_d = i_fifo_data;
        end else if (pop) begin
          tail_d = i_fifo_data;
          occ_d  = 2'd2;
        end else if (xfer) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        if (xfer) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  // NOTE: the data registers are reset too, because o_data must read zero out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q <= S_IDLE;
      rem_q   <= '0;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_remaining = rem_q;
  assign o_fifo_read = pop;
  assign o_valid     = (occ_q != 2'd0);
  assign o_data      = head_q;

endmodule

// File: tb/tb_vec_fifo_reader.sv
// Randomised scoreboard bench for vec_fifo_reader: a queue-based FWFT FIFO model feeds
// the DUT, and a negedge monitor checks every transfer, pop and done pulse.
module tb_vec_fifo_reader;
  localparam int WIDTH   = 248;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  typedef logic [WIDTH-1:0] word_t;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_start = 1'b0;
  logic [LEN_W-1:0] i_len = '0;
  logic             i_fifo_empty = 1'b1;
  word_t            i_fifo_data = '0;
  logic             i_ready = 1'b0;
  logic             o_busy, o_done, o_fifo_read, o_valid;
  logic [LEN_W-1:0] o_remaining;
  word_t            o_data;

  always #5 i_clk = ~i_clk;

  vec_fifo_reader #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_remaining(o_remaining),
    .o_fifo_read(o_fifo_read), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready)
  );

  int    checks = 0, failures = 0, cyc = 0;
  word_t fifo_q[$], wr_pend[$], exp_q[$];
  logic  pop_seen = 1'b0;
  int    total_pops = 0, pop_base = 0, burst_len = 0, done_count = 0;
  int    first_pop_cyc = -1, last_pop_cyc = -1, first_xfer_cyc = -1, last_xfer_cyc = -1;
  int    done_cyc = -1, ready_mode = 0;
  logic  prev_stall = 1'b0;
  word_t prev_data = '0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // FWFT FIFO model: pop seen in the previous cycle applied, then pending writes appended.
  always @(posedge i_clk) begin
    #1;
    if (!i_rstn) begin
      fifo_q.delete();
    end else begin
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
    end
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  always @(posedge i_clk) begin
    #2;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: all DUT outputs sampled mid-cycle.
  always @(negedge i_clk) begin
    pop_seen = o_fifo_read;
    if (i_rstn) begin
      if (o_busy) check_int("remaining", int'(o_remaining), burst_len - (total_pops - pop_base));
      else        check_int("remaining_idle", int'(o_remaining), 0);
      if (o_fifo_read) begin
        check_int("pop_nonempty", int'(i_fifo_empty), 0);
        if (total_pops == pop_base) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        total_pops++;
      end
      if (prev_stall) begin
        check_int("stall_valid", int'(o_valid), 1);
        check_word("stall_data", o_data, prev_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL xfer_unexpected: got %h expected no transfer", o_data);
        end else begin
          check_word("data", o_data, exp_q.pop_front());
        end
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (o_done) begin
        check_int("done_all_delivered", exp_q.size(), 0);
        check_int("done_pop_count", total_pops - pop_base, burst_len);
        if (burst_len > 0) check_int("done_latency", cyc, last_xfer_cyc + 1);
        done_cyc = cyc;
        done_count++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // One burst: len entries, prefill of them in the FIFO before start, the rest written
  // from cycle 'gap' onward. Optional extra start pulse and a ready release point.
  task automatic run_burst(input int len, input int prefill, input int gap,
                           input bit trickle, input bit extra_start, input int hold,
                           output int start_cyc);
    word_t w[$];
    int idx, budget, target;
    for (int i = 0; i < len; i++) begin
      w.push_back(rand_word());
      exp_q.push_back(w[i]);
    end
    for (int i = 0; i < prefill; i++) wr_pend.push_back(w[i]);
    step();
    burst_len      = len;
    pop_base       = total_pops;
    first_xfer_cyc = -1;
    target         = done_count + 1;
    i_start        = 1'b1;
    i_len          = LEN_W'(len);
    start_cyc      = cyc;
    step();
    i_start = 1'b0;
    idx     = prefill;
    budget  = 0;
    while (done_count < target && budget < 3000) begin
      if (idx < len && budget >= gap && (!trickle || $urandom_range(0, 3) != 0)) begin
        wr_pend.push_back(w[idx]);
        idx++;
      end
      if (extra_start && budget == 3) begin
        i_start = 1'b1;
        i_len   = LEN_W'(5);
      end else begin
        i_start = 1'b0;
      end
      if (hold >= 0 && budget == hold) begin
        check_int("stall_pop_count", total_pops - pop_base, 2);
        ready_mode = 0;
      end
      step();
      budget++;
    end
    i_start = 1'b0;
    if (done_count < target) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_count, target);
    end
  endtask

  initial begin
    int sc, len;
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int sc, len;
    step(2);
    check_int("rst_valid", int'(o_valid), 0);
    check_int("rst_busy", int'(o_busy), 0);
    check_int("rst_done", int'(o_done), 0);
    check_int("rst_fifo_read", int'(o_fifo_read), 0);
    check_int("rst_remaining", int'(o_remaining), 0);
    check_word("rst_data", o_data, '0);
    i_rstn = 1'b1;
    step(2);

    // Back-to-back burst of 4 with ready held high.
    ready_mode = 0;
    step();
    run_burst(4, 4, 0, 1'b0, 1'b0, -1, sc);
    check_int("t1_pop_span", last_pop_cyc - first_pop_cyc, 3);
    check_int("t1_first_pop", first_pop_cyc, sc + 1);
    check_int("t1_first_xfer", first_xfer_cyc, first_pop_cyc + 1);
    check_int("t1_fifo_empty", fifo_q.size() + wr_pend.size(), 0);

    // Zero-length burst.
    run_burst(0, 0, 0, 1'b0, 1'b0, -1, sc);
    check_int("t2_done_at", done_cyc, sc + 1);

    // Downstream stalled for 10 cycles.
    ready_mode = 2;
    run_burst(8, 8, 0, 1'b0, 1'b0, 10, sc);

    // FIFO holds one entry, the other two arrive five cycles later.
    ready_mode = 0;
    run_burst(3, 1, 5, 1'b0, 1'b0, -1, sc);

    // Second start during RUN must be ignored.
    ready_mode = 1;
    run_burst(12, 2, 2, 1'b1, 1'b1, -1, sc);

    // Asynchronous reset with remaining=3 and a full skid buffer.
    ready_mode = 2;
    step();
    begin
      word_t w;
      for (int i = 0; i < 5; i++) begin
        w = rand_word();
        wr_pend.push_back(w);
      end
    end
    step();
    burst_len = 5;
    pop_base  = total_pops;
    i_start   = 1'b1;
    i_len     = LEN_W'(5);
    step();
    i_start = 1'b0;
    step(5);
    check_int("t6_remaining_before", int'(o_remaining), 3);
    check_int("t6_valid_before", int'(o_valid), 1);
    #1;
    i_rstn = 1'b0;
    #1;
    check_int("t6_valid_rst", int'(o_valid), 0);
    check_int("t6_busy_rst", int'(o_busy), 0);
    check_int("t6_remaining_rst", int'(o_remaining), 0);
    exp_q.delete();
    step(2);
    i_rstn     = 1'b1;
    ready_mode = 0;
    step(2);
    run_burst(6, 6, 0, 1'b0, 1'b0, -1, sc);

    // Randomised bursts, then one maximum-length burst.
    ready_mode = 1;
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(0, 20);
      run_burst(len, $urandom_range(0, len), $urandom_range(0, 6), 1'b1, 1'b0, -1, sc);
    end
    run_burst(MAX_LEN, MAX_LEN, 0, 1'b0, 1'b0, -1, sc);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
